shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier_if.sv | 13 +
 rtl/shift_add_multiplier.sv | 91 +++++++++
 tb/tb_shift_add_multiplier.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// Request/response bundle for the sequential shift-add multiplier.
// The requester drives start/a/b; the multiplier returns busy/done/product.
interface shift_add_multiplier_if #(parameter int WIDTH = 16);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier.sv
// Unsigned radix-2 shift-add multiplier.
// It retires one multiplier bit per cycle, so the latency is WIDTH cycles from the accepted start to done.
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     sum;

  // The extra top bit of sum holds the carry-out, and the right shift brings it back into range.
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    product_d = product_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.a;
          acc_d   = {{WIDTH{1'b0}}, bus.b};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          product_d = acc_d;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      product_q <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier at WIDTH=16.
// It applies directed vectors, hand-written corner sequences, and random operands checked against plain a*b.
module tb_shift_add_multiplier;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [2*W-1:0] prev;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    string          nm;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full operation: latency, busy window, result, and hold-after-done.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                       input logic [2*W-1:0] exp, input string nm, input bit poke);
    int n;
    int busy_bad;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    chk({nm, "_busy_at_accept"}, 64'(bus.busy), 64'd1);
    n = 0; busy_bad = 0;
    while (n < 20 && !bus.done) begin
      if (!bus.busy || bus.done) busy_bad++;
      if (bus.product !== prev) busy_bad++;
      if (poke && n == 5) begin
        bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'hAAAA;
      end else if (poke && n == 6) begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd16);
    chk({nm, "_busy_window"}, 64'(busy_bad), 64'd0);
    chk({nm, "_busy_with_done"}, 64'(bus.busy), 64'd0);
    chk({nm, "_product"}, 64'(bus.product), 64'(exp));
    prev = exp;
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, 64'(bus.done), 64'd0);
    chk({nm, "_product_hold"}, 64'(bus.product), 64'(exp));
  endtask

  initial begin
    int cnt;
    int last;
    int edges;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] rp;

    vecs[0] = '{a: 16'd3,    b: 16'd5,    p: 32'h0000000F, nm: "v3x5"};
    vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE0001, nm: "vffffxffff"};
    vecs[2] = '{a: 16'h1234, b: 16'h0000, p: 32'h00000000, nm: "v1234x0"};
    vecs[3] = '{a: 16'h8000, b: 16'h0002, p: 32'h00010000, nm: "v8000x2"};
    vecs[4] = '{a: 16'h0001, b: 16'hFFFF, p: 32'h0000FFFF, nm: "v1xffff"};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    prev = '0;
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_product", 64'(bus.product), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].nm, 1'b0);

    // A start pulse during CALC is ignored, and the result belongs to the original operands.
    do_op(16'd7, 16'd9, 32'h3F, "ignore_start", 1'b1);
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) cnt++;
    end
    chk("ignore_start_no_extra_done", 64'(cnt), 64'd0);
    chk("ignore_start_product_kept", 64'(bus.product), 64'h3F);

    // An asynchronous reset mid-CALC abandons the operation immediately.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd200;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(bus.busy), 64'd0);
    chk("midreset_done", 64'(bus.done), 64'd0);
    chk("midreset_product", 64'(bus.product), 64'd0);
    prev = '0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done || bus.product != 0) cnt++;
    end
    chk("midreset_quiet", 64'(cnt), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    do_op(16'd2, 16'd3, 32'd6, "after_reset", 1'b0);

    // With start held high, done pulses at the back-to-back period of WIDTH+2.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h8000; bus.b = 16'd2;
    cnt = 0; last = -1; edges = 0;
    repeat (80) begin
      @(posedge clk); #1;
      edges++;
      if (bus.done) begin
        chk("b2b_product", 64'(bus.product), 64'h00010000);
        chk("b2b_busy_low", 64'(bus.busy), 64'd0);
        if (last >= 0) chk("b2b_period", 64'(edges - last), 64'd18);
        last = edges;
        cnt++;
      end
    end
    chk("b2b_pulse_count", 64'(cnt), 64'd4);
    bus.start = 1'b0;
    prev = 32'h00010000;
    repeat (20) @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) ra = '0;
      if (i == 1) rb = 16'h8000;
      rp = 32'(ra) * 32'(rb);
      do_op(ra, rb, rp, $sformatf("rand%0d", i), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
